mux_rr_pipe: RTL and testbench

MUX_RR_PIPE -- requirements
Module: mux_rr_pipe

---
 rtl/mux_rr_pipe.sv | 110 +++++++++++
 tb/tb_mux_rr_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_pipe
// Purpose  : N-to-1 valid/ready mux into a single-entry output register,
//            channel chosen by external select or by round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src,
  output logic                    sel_err
);

  localparam logic [SEL_W:0]   c_num_in = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] c_last   = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_src;
  logic             r_out_valid;
  logic             r_sel_err;
  logic [SEL_W-1:0] r_rr_ptr;

  logic [WIDTH-1:0] w_ch [NUM_IN];
  logic             w_can_load;
  logic             w_sel_ok;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W:0]   w_cand;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_xfer;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
    assign w_ch[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  assign w_can_load = !r_out_valid || out_ready;
  assign w_sel_ok   = ({1'b0, sel} < c_num_in);

  // Round-robin search: first valid channel at or after r_rr_ptr, modulo NUM_IN.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_cand     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_cand = {1'b0, r_rr_ptr} + k[SEL_W:0];
      if (w_cand >= c_num_in) w_cand = w_cand - c_num_in;
      if (!w_rr_found && in_valid[w_cand[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    in_ready  = '0;
    if (MODE == 0) begin
      w_gnt_vld = w_sel_ok;
      w_gnt_idx = sel;
    end else begin
      w_gnt_vld = w_rr_found;
      w_gnt_idx = w_rr_idx;
    end
    if (rst_n && w_gnt_vld && w_can_load) in_ready[w_gnt_idx] = 1'b1;
  end

  assign w_xfer = w_gnt_vld && w_can_load && in_valid[w_gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_sel_err <= (MODE == 0) && !w_sel_ok && (|in_valid);
      if (w_xfer) begin
        r_out_data  <= w_ch[w_gnt_idx];
        r_out_src   <= w_gnt_idx;
        r_out_valid <= 1'b1;
        if (MODE != 0) r_rr_ptr <= (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_pipe
// Purpose  : Self-checking bench for mux_rr_pipe in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux_rr_pipe;

  localparam int c_ndut = 3;
  localparam int c_w    = 32;
  localparam int c_mode [c_ndut] = '{0, 1, 0};
  localparam int c_num  [c_ndut] = '{4, 4, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [3:0]       iv   [c_ndut];
  logic [4*c_w-1:0] idat [c_ndut];
  logic [1:0]       sel  [c_ndut];
  logic             ordy [c_ndut];

  wire [3:0]     rdy0, rdy1;
  wire [2:0]     rdy2;
  wire [c_w-1:0] od0, od1, od2;
  wire           ov0, ov1, ov2, se0, se1, se2;
  wire [1:0]     os0, os1, os2;

  mux_rr_pipe #(.WIDTH(c_w), .NUM_IN(4), .SEL_W(2), .MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(idat[0]), .in_valid(iv[0]), .in_ready(rdy0),
    .sel(sel[0]), .out_data(od0), .out_valid(ov0), .out_ready(ordy[0]),
    .out_src(os0), .sel_err(se0));
  mux_rr_pipe #(.WIDTH(c_w), .NUM_IN(4), .SEL_W(2), .MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(idat[1]), .in_valid(iv[1]), .in_ready(rdy1),
    .sel(sel[1]), .out_data(od1), .out_valid(ov1), .out_ready(ordy[1]),
    .out_src(os1), .sel_err(se1));
  mux_rr_pipe #(.WIDTH(c_w), .NUM_IN(3), .SEL_W(2), .MODE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(idat[2][3*c_w-1:0]), .in_valid(iv[2][2:0]),
    .in_ready(rdy2), .sel(sel[2]), .out_data(od2), .out_valid(ov2),
    .out_ready(ordy[2]), .out_src(os2), .sel_err(se2));

  function automatic logic [3:0] get_rdy(int d);
    case (d) 0: return rdy0; 1: return rdy1; default: return {1'b0, rdy2}; endcase
  endfunction
  function automatic logic [c_w-1:0] get_od(int d);
    case (d) 0: return od0; 1: return od1; default: return od2; endcase
  endfunction
  function automatic logic get_ov(int d);
    case (d) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction
  function automatic logic [1:0] get_os(int d);
    case (d) 0: return os0; 1: return os1; default: return os2; endcase
  endfunction
  function automatic logic get_se(int d);
    case (d) 0: return se0; 1: return se1; default: return se2; endcase
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one output slot per DUT plus the arbitration pointer.
  logic           m_valid [c_ndut];
  logic [c_w-1:0] m_data  [c_ndut];
  int             m_src   [c_ndut];
  int             m_rr    [c_ndut];
  logic           m_err   [c_ndut];

  task automatic model_reset();
    for (int d = 0; d < c_ndut; d++) begin
      m_valid[d] = 1'b0; m_data[d] = '0; m_src[d] = 0; m_rr[d] = 0; m_err[d] = 1'b0;
    end
  endtask

  function automatic logic [3:0] exp_ready(int d);
    logic [3:0] r;
    int n;
    logic can;
    r   = '0;
    n   = c_num[d];
    can = !m_valid[d] || ordy[d];
    if (!rst_n) return r;
    if (c_mode[d] == 0) begin
      if (int'(sel[d]) < n && can) r[sel[d]] = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        int ch;
        ch = (m_rr[d] + k) % n;
        if (iv[d][ch]) begin
          if (can) r[ch] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic model_step(int d);
    logic [3:0] r;
    int g;
    r = exp_ready(d);
    g = -1;
    for (int i = 0; i < c_num[d]; i++) if (r[i] && iv[d][i]) g = i;
    m_err[d] = (c_mode[d] == 0) && (int'(sel[d]) >= c_num[d]) && (iv[d] != 4'b0);
    if (g >= 0) begin
      m_valid[d] = 1'b1;
      m_data[d]  = idat[d][g*c_w +: c_w];
      m_src[d]   = g;
      if (c_mode[d] == 1) m_rr[d] = (g + 1) % c_num[d];
    end else if (m_valid[d] && ordy[d]) begin
      m_valid[d] = 1'b0;
    end
  endtask

  task automatic tick_pre();
    #1;
    for (int d = 0; d < c_ndut; d++) begin
      chk($sformatf("d%0d.in_ready", d), 32'(get_rdy(d)), 32'(exp_ready(d)));
      model_step(d);
    end
  endtask

  task automatic tick_post();
    @(posedge clk);
    #1;
    for (int d = 0; d < c_ndut; d++) begin
      chk($sformatf("d%0d.out_valid", d), 32'(get_ov(d)), 32'(m_valid[d]));
      chk($sformatf("d%0d.out_data", d), get_od(d), m_data[d]);
      chk($sformatf("d%0d.out_src", d), 32'(get_os(d)), 32'(m_src[d]));
      chk($sformatf("d%0d.sel_err", d), 32'(get_se(d)), 32'(m_err[d]));
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < c_ndut; d++) begin
      iv[d] = '0; sel[d] = '0; ordy[d] = 1'b1;
      for (int ch = 0; ch < 4; ch++) idat[d][ch*c_w +: c_w] = 32'hA5A5_0000 | 32'(ch);
    end
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int         d;
    logic [3:0] iv;
    logic [1:0] sel;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] src;
    logic       err;
  } vec_t;

  vec_t vecs [13];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{0, 4'b0110, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[1]  = '{0, 4'b0000, 2'd3, 1'b1, 4'b1000, 1'b0, 2'd2, 1'b0};
    vecs[2]  = '{0, 4'b0001, 2'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[3]  = '{0, 4'b0010, 2'd1, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};
    vecs[4]  = '{2, 4'b0001, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[5]  = '{2, 4'b0000, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{2, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[7]  = '{1, 4'b1010, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[8]  = '{1, 4'b1010, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[9]  = '{1, 4'b0000, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};
    vecs[10] = '{1, 4'b0100, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[11] = '{1, 4'b0001, 2'd3, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[12] = '{1, 4'b1111, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};

    idle_all();
    model_reset();
    #2;
    for (int d = 0; d < c_ndut; d++) begin
      chk($sformatf("d%0d.reset_ready", d), 32'(get_rdy(d)), 32'd0);
      chk($sformatf("d%0d.reset_valid", d), 32'(get_ov(d)), 32'd0);
    end
    do_reset();
    tick_post();

    // Table-driven vectors
    foreach (vecs[i]) begin
      idle_all();
      iv[vecs[i].d]   = vecs[i].iv;
      sel[vecs[i].d]  = vecs[i].sel;
      ordy[vecs[i].d] = vecs[i].ordy;
      tick_pre();
      chk($sformatf("vec%0d.in_ready", i), 32'(get_rdy(vecs[i].d)), 32'(vecs[i].rdy));
      tick_post();
      chk($sformatf("vec%0d.out_valid", i), 32'(get_ov(vecs[i].d)), 32'(vecs[i].ov));
      chk($sformatf("vec%0d.out_src", i), 32'(get_os(vecs[i].d)), 32'(vecs[i].src));
      chk($sformatf("vec%0d.sel_err", i), 32'(get_se(vecs[i].d)), 32'(vecs[i].err));
      if (vecs[i].ov)
        chk($sformatf("vec%0d.out_data", i), get_od(vecs[i].d), 32'hA5A5_0000 | 32'(vecs[i].src));
    end

    // Round-robin streaming with all channels valid
    do_reset();
    idle_all();
    iv[1] = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick_pre();
      tick_post();
      chk($sformatf("rr_stream%0d.src", k), 32'(get_os(1)), 32'(k % 4));
      chk($sformatf("rr_stream%0d.valid", k), 32'(get_ov(1)), 32'd1);
    end

    // Backpressure: hold, then drain and reload in one cycle
    idle_all();
    sel[0] = 2'd1; iv[0] = 4'b0010; ordy[0] = 1'b0;
    idat[0][1*c_w +: c_w] = 32'h1111_1111;
    tick_pre();
    tick_post();
    for (int k = 0; k < 3; k++) begin
      sel[0] = 2'd2; iv[0] = 4'b0100; ordy[0] = 1'b0;
      idat[0][2*c_w +: c_w] = $urandom;
      tick_pre();
      chk($sformatf("bp%0d.ready", k), 32'(get_rdy(0)), 32'd0);
      tick_post();
      chk($sformatf("bp%0d.data", k), get_od(0), 32'h1111_1111);
    end
    ordy[0] = 1'b1;
    idat[0][2*c_w +: c_w] = 32'hBEEF_0002;
    tick_pre();
    chk("bp_release.ready", 32'(get_rdy(0)), 32'b0100);
    tick_post();
    chk("bp_release.valid", 32'(get_ov(0)), 32'd1);
    chk("bp_release.data", get_od(0), 32'hBEEF_0002);

    // Reset mid-stream; pointer restarts at 0 afterwards
    do_reset();
    idle_all();
    iv[1] = 4'b1111;
    tick_pre(); tick_post();
    ordy[1] = 1'b0;
    tick_pre(); tick_post();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.valid", 32'(get_ov(1)), 32'd0);
    chk("midrst.ready1", 32'(get_rdy(1)), 32'd0);
    chk("midrst.ready0", 32'(get_rdy(0)), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_all();
    iv[1] = 4'b0110;
    tick_pre();
    tick_post();
    chk("postrst.src", 32'(get_os(1)), 32'd1);
    chk("postrst.valid", 32'(get_ov(1)), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < c_ndut; d++) begin
        iv[d]   = 4'($urandom_range(0, 15));
        if (c_num[d] == 3) iv[d][3] = 1'b0;
        sel[d]  = 2'($urandom_range(0, 3));
        ordy[d] = ($urandom_range(0, 3) != 0);
        for (int ch = 0; ch < 4; ch++) idat[d][ch*c_w +: c_w] = $urandom;
      end
      tick_pre();
      tick_post();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
